// File: rtl/reg_seq_pkg.sv
// Shared types and constants for the reg_sequencer fetch/decode/execute controller:
// state encoding, instruction field positions, selector constants and operand classification.
package reg_seq_pkg;

   typedef enum logic [2:0] {
      FETCH,
      DECODE,
      SRC_READ,
      DST_WRITE,
      COMMIT,
      HALT,
      ERROR
   } seq_state_e;

   localparam int DST_HI    = 15;
   localparam int DST_LO    = 13;
   localparam int SRC_HI    = 12;
   localparam int SRC_LO    = 10;
   localparam int STORE_BIT = 9;
   localparam int INC_BIT   = 8;
   localparam int DEC_BIT   = 7;
   localparam int IMM_HI    = 6;
   localparam int IMM_LO    = 0;

   localparam logic [2:0] SEL_PC    = 3'd0;
   localparam logic [2:0] SEL_FLAGS = 3'd4;

   // r1..r3 hold memory addresses; PC, flags and the upper registers are direct operands.
   function automatic logic is_mem_operand(input logic [2:0] sel);
      return !sel[2] && (sel != SEL_PC);
   endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: splits the instruction register into register_block
// selects, immediate, and the store/increment/decrement controls used by the sequencer.
module seq_decode
   import reg_seq_pkg::*;
(
   input  logic [15:0] instr,
   output logic [2:0]  dst_sel,
   output logic [2:0]  src_sel,
   output logic [6:0]  imm,
   output logic        store_en,
   output logic        inc_en,
   output logic        dec_en,
   output logic        src_is_mem,
   output logic        dst_is_mem,
   output logic        src_is_imm,
   output logic        dst_is_flags
);

   always_comb begin
      dst_sel      = instr[DST_HI:DST_LO];
      src_sel      = instr[SRC_HI:SRC_LO];
      imm          = instr[IMM_HI:IMM_LO];
      store_en     = instr[STORE_BIT];
      inc_en       = instr[INC_BIT];
      dec_en       = instr[DEC_BIT];
      src_is_mem   = is_mem_operand(src_sel);
      dst_is_mem   = is_mem_operand(dst_sel);
      src_is_imm   = (src_sel == SEL_FLAGS);
      dst_is_flags = (dst_sel == SEL_FLAGS);
   end

endmodule

// File: rtl/reg_sequencer.sv
// Multi-cycle fetch/decode/execute controller owning PC, instruction register and the memory port.
// Optional SEQ_HALT_EN: instruction 16'h0000 halts the core instead of acting as a NOP.
module reg_sequencer
   import reg_seq_pkg::*;
#(
   parameter logic [15:0] RESET_PC    = 16'h0000,
   parameter int unsigned ACK_TIMEOUT = 64
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack,
   output logic [15:0] pc,
   output logic [2:0]  source_select,
   output logic [2:0]  destination_select,
   output logic [6:0]  immediate,
   output logic        source_immediate,
   output logic [15:0] destination_write,
   output logic        store_value,
   output logic        set_flags,
   output logic        pre_increment,
   output logic        post_increment,
   output logic        decrement,
   input  logic [15:0] source_out,
   input  logic [15:0] destination_out,
   output logic        halted,
   output logic        bus_error
);

   localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1) + 1;

   seq_state_e        state_q, state_d;
   logic [15:0]       pc_q, pc_d;
   logic [15:0]       instr_q, instr_d;
   logic [15:0]       operand_q, operand_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [15:0]       dest_write_q, dest_write_d;
   logic              store_value_q, store_value_d;
   logic              set_flags_q, set_flags_d;
   logic              pre_inc_q, pre_inc_d;
   logic              post_inc_q, post_inc_d;
   logic              decrement_q, decrement_d;
   logic              bus_error_q, bus_error_d;

   logic [2:0] dst_sel, src_sel;
   logic [6:0] imm;
   logic       store_en, inc_en, dec_en, src_is_mem, dst_is_mem, src_is_imm, dst_is_flags;
   logic       acked, awaiting, timed_out;
   seq_state_e exec_next;

   seq_decode u_decode (
      .instr        (instr_q),
      .dst_sel      (dst_sel),
      .src_sel      (src_sel),
      .imm          (imm),
      .store_en     (store_en),
      .inc_en       (inc_en),
      .dec_en       (dec_en),
      .src_is_mem   (src_is_mem),
      .dst_is_mem   (dst_is_mem),
      .src_is_imm   (src_is_imm),
      .dst_is_flags (dst_is_flags)
   );

   // An ack only counts while our request is actually on the bus.
   assign acked     = mem_req_q && mem_ack;
   assign awaiting  = mem_req_q && !mem_ack;
   assign timed_out = (ACK_TIMEOUT != 0) && (wait_q == WAIT_W'(ACK_TIMEOUT - 1));
   assign exec_next = (store_en && dst_is_mem) ? DST_WRITE : COMMIT;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      operand_d = operand_q;
      wait_d    = '0;
      case (state_q)
         FETCH: if (acked) begin
            instr_d = mem_rdata;
            state_d = DECODE;
         end
         DECODE: begin
`ifdef SEQ_HALT_EN
            if (instr_q == 16'h0000) state_d = HALT;
            else
`endif
            if (src_is_mem) state_d = SRC_READ;
            else begin
               operand_d = source_out;
               state_d   = exec_next;
            end
         end
         SRC_READ: if (acked) begin
            operand_d = mem_rdata;
            state_d   = exec_next;
         end
         DST_WRITE: if (acked) state_d = COMMIT;
         COMMIT: begin
            pc_d    = (store_en && dst_sel == SEL_PC) ? operand_q : pc_q + 16'd1;
            state_d = FETCH;
         end
         default: ;
      endcase
      if (awaiting) begin
         if (timed_out) state_d = ERROR;
         else           wait_d  = wait_q + 1'b1;
      end

      // Outputs are registered: compute what they must be in the state being entered.
      mem_req_d     = (state_d == FETCH) || (state_d == SRC_READ) || (state_d == DST_WRITE);
      mem_we_d      = (state_d == DST_WRITE);
      pre_inc_d     = (state_d == DST_WRITE) && inc_en && dec_en;
      post_inc_d    = (state_d == COMMIT) && inc_en;
      decrement_d   = pre_inc_d || ((state_d == COMMIT) && dec_en);
      dest_write_d  = (state_d == COMMIT) ? operand_d : 16'h0000;
      store_value_d = (state_d == COMMIT) && store_en && !dst_is_mem;
      set_flags_d   = (state_d == COMMIT) && store_en && !dst_is_flags;
      bus_error_d   = bus_error_q || (state_d == ERROR);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= FETCH;
         pc_q          <= RESET_PC;
         instr_q       <= '0;
         operand_q     <= '0;
         wait_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         dest_write_q  <= '0;
         store_value_q <= 1'b0;
         set_flags_q   <= 1'b0;
         pre_inc_q     <= 1'b0;
         post_inc_q    <= 1'b0;
         decrement_q   <= 1'b0;
         bus_error_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_q       <= instr_d;
         operand_q     <= operand_d;
         wait_q        <= wait_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         dest_write_q  <= dest_write_d;
         store_value_q <= store_value_d;
         set_flags_q   <= set_flags_d;
         pre_inc_q     <= pre_inc_d;
         post_inc_q    <= post_inc_d;
         decrement_q   <= decrement_d;
         bus_error_q   <= bus_error_d;
      end
   end

`ifdef SEQ_HALT_EN
   logic halted_q;
   always_ff @(posedge clock or posedge reset) begin
      if (reset) halted_q <= 1'b0;
      else       halted_q <= (state_d == HALT);
   end
   assign halted = halted_q;
`else
   assign halted = 1'b0;
`endif

   // Data-side addresses follow register_block live, so pre-decremented bases appear directly.
   always_comb begin
      case (state_q)
         SRC_READ:  mem_addr = source_out;
         DST_WRITE: mem_addr = destination_out;
         default:   mem_addr = pc_q;
      endcase
   end

   assign mem_req            = mem_req_q;
   assign mem_we             = mem_we_q;
   assign mem_wdata          = operand_q;
   assign pc                 = pc_q;
   assign source_select      = src_sel;
   assign destination_select = dst_sel;
   assign immediate          = imm;
   assign source_immediate   = src_is_imm;
   assign destination_write  = dest_write_q;
   assign store_value        = store_value_q;
   assign set_flags          = set_flags_q;
   assign pre_increment      = pre_inc_q;
   assign post_increment     = post_inc_q;
   assign decrement          = decrement_q;
   assign bus_error          = bus_error_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// Self-checking bench for reg_sequencer: directed and random instructions against a
// transaction-level reference model; also covers timeout, reset and halt/NOP behaviour.
module tb_reg_sequencer;

   localparam logic [15:0] RST_PC = 16'h0100;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic [15:0] pc, destination_write, source_out, destination_out;
   logic [2:0]  source_select, destination_select;
   logic [6:0]  immediate;
   logic        source_immediate, store_value, set_flags;
   logic        pre_increment, post_increment, decrement, halted, bus_error;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_pc;

   reg_sequencer #(.RESET_PC(RST_PC), .ACK_TIMEOUT(4)) dut (
      .clock              (clock),
      .reset              (reset),
      .mem_req            (mem_req),
      .mem_we             (mem_we),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_rdata          (mem_rdata),
      .mem_ack            (mem_ack),
      .pc                 (pc),
      .source_select      (source_select),
      .destination_select (destination_select),
      .immediate          (immediate),
      .source_immediate   (source_immediate),
      .destination_write  (destination_write),
      .store_value        (store_value),
      .set_flags          (set_flags),
      .pre_increment      (pre_increment),
      .post_increment     (post_increment),
      .decrement          (decrement),
      .source_out         (source_out),
      .destination_out    (destination_out),
      .halted             (halted),
      .bus_error          (bus_error)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] strobes();
      return {store_value, set_flags, pre_increment, post_increment, decrement};
   endfunction

   // Called on the negedge where a request must be visible; acks after 'waits' idle cycles.
   task automatic serve(input string tag, input logic [15:0] addr, input logic we,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int waits, input logic [4:0] exp_strobes);
      check_value({tag, " req"}, mem_req, 1);
      check_value({tag, " addr"}, mem_addr, addr);
      check_value({tag, " we"}, mem_we, we);
      if (we) check_value({tag, " wdata"}, mem_wdata, wdata);
      check_value({tag, " strobes"}, strobes(), exp_strobes);
      for (int i = 0; i < waits; i++) begin
         @(negedge clock);
         check_value({tag, " held"}, {mem_req, bus_error}, 2'b10);
      end
      mem_ack   = 1'b1;
      mem_rdata = rdata;
      @(negedge clock);
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
   endtask

   // Reference: one instruction as a list of bus transactions and a commit result.
   task automatic run_instr(input logic [15:0] ins, input logic [15:0] sv, input logic [15:0] dv,
                            input logic [15:0] rd, input int w);
      int          d, s;
      logic        st, inc, dec, src_mem, dst_mem, do_write, pd;
      logic [15:0] operand;
      d        = int'(ins[15:13]);
      s        = int'(ins[12:10]);
      st       = ins[9];
      inc      = ins[8];
      dec      = ins[7];
      src_mem  = (s >= 1 && s <= 3);
      dst_mem  = (d >= 1 && d <= 3);
      operand  = src_mem ? rd : sv;
      do_write = st && dst_mem;
      pd       = inc && dec;
      source_out      = sv;
      destination_out = dv;
      serve("fetch", exp_pc, 1'b0, 16'h0, ins, w, 5'b0);
      check_value("decode req", mem_req, 0);
      check_value("decode fields", {destination_select, source_select, immediate, source_immediate},
                  {ins[15:13], ins[12:10], ins[6:0], (s == 4)});
      check_value("decode strobes", strobes(), 0);
      mem_ack = 1'($urandom_range(0, 1));
      @(negedge clock);
      mem_ack = 1'b0;
      if (src_mem) serve("src read", sv, 1'b0, 16'h0, rd, w, 5'b0);
      if (do_write) serve("dst write", dv, 1'b1, operand, 16'($urandom), w, {2'b00, pd, 1'b0, pd});
      check_value("commit req", mem_req, 0);
      check_value("commit dwrite", destination_write, operand);
      check_value("commit strobes", strobes(), {st && !dst_mem, st && (d != 4), 1'b0, inc, dec});
      exp_pc = (st && d == 0) ? operand : exp_pc + 16'd1;
      @(negedge clock);
      check_value("next pc", pc, exp_pc);
      $display("instr %h src %h dst %h rd %h waits %0d -> pc %h", ins, sv, dv, rd, w, exp_pc);
   endtask

   task automatic do_reset();
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check_value("reset req", {mem_req, mem_we}, 0);
      check_value("reset pc", pc, RST_PC);
      check_value("reset flags", {bus_error, halted}, 0);
      check_value("reset strobes", strobes(), 0);
      @(negedge clock);
      reset = 1'b0;
      exp_pc = RST_PC;
      @(negedge clock);
   endtask

   initial begin
      mem_ack = 1'b0; mem_rdata = 16'h0; source_out = 16'h0; destination_out = 16'h0;
      exp_pc = RST_PC;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check_value("reset req", mem_req, 0);
      check_value("reset pc", pc, RST_PC);
      check_value("reset flags", {bus_error, halted, mem_we}, 0);
      check_value("reset strobes", strobes(), 0);
      reset = 1'b0;
      @(negedge clock);
      check_value("first fetch addr", mem_addr, RST_PC);

      run_instr(16'hA205, 16'h5A5A, 16'h1111, 16'h2222, 0);
      run_instr(16'h2B80, 16'h0200, 16'h0300, 16'h1234, 0);
      run_instr(16'h1600, 16'h0040, 16'h0000, 16'h0000, 0);
      run_instr(16'hA205, 16'h0007, 16'h0000, 16'h0000, 1);
      run_instr(16'h1600, 16'hFFFF, 16'h0000, 16'h0000, 0);
      run_instr(16'hA205, 16'h0008, 16'h0000, 16'h0000, 0);
      check_value("pc wrap", pc, 16'h0000);

      for (int k = 0; k < 40; k++) begin
         logic [15:0] ins;
         ins = 16'($urandom);
         if (ins == 16'h0000) ins = 16'h0001;
         run_instr(ins, 16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 3)));
      end

`ifdef SEQ_HALT_EN
      source_out = 16'h3333;
      serve("halt fetch", exp_pc, 1'b0, 16'h0, 16'h0000, 0, 5'b0);
      check_value("halt decode", halted, 0);
      @(negedge clock);
      for (int i = 0; i < 5; i++) begin
         mem_ack = 1'($urandom_range(0, 1));
         check_value("halted", {halted, mem_req}, 2'b10);
         check_value("halt pc", pc, exp_pc);
         @(negedge clock);
      end
      mem_ack = 1'b0;
      $display("halt at %h", exp_pc);
      do_reset();
`else
      run_instr(16'h0000, 16'h3333, 16'h4444, 16'h5555, 0);
      check_value("nop not halted", halted, 0);
      do_reset();
`endif

      check_value("timeout start", {mem_req, mem_addr}, {1'b1, RST_PC});
      for (int i = 1; i < 4; i++) begin
         @(negedge clock);
         check_value("timeout wait", {mem_req, bus_error}, 2'b10);
      end
      @(negedge clock);
      check_value("timeout error", {mem_req, bus_error}, 2'b01);
      mem_ack = 1'b1;
      repeat (2) @(negedge clock);
      mem_ack = 1'b0;
      check_value("error sticky", {mem_req, bus_error}, 2'b01);
      $display("timeout -> bus_error %b", bus_error);

      do_reset();
      check_value("post reset", {mem_req, bus_error, mem_addr}, {2'b10, RST_PC});
      repeat (2) @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check_value("reset mid wait", mem_req, 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_value("refetch", {mem_req, bus_error, mem_addr}, {2'b10, RST_PC});
      exp_pc = RST_PC;
      run_instr(16'hA205, 16'h0099, 16'h0000, 16'h0000, 3);
      $display("reset mid wait -> refetch at %h", RST_PC);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
